// File: rtl/exu_cal_arb.sv
// Round-robin arbiter that shares one CAL (adder/comparator) among NREQ EXU requesters.
// One operation in flight; operands and result are registered between val/rdy handshakes.
module exu_cal_arb #(
   parameter int NREQ  = 2,
   parameter int OPB_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_val,
   output logic [NREQ-1:0]       req_rdy,
   input  logic [NREQ*OPB_W-1:0] req_opb,
   input  logic [NREQ*32-1:0]    req_opn1,
   input  logic [NREQ*32-1:0]    req_opn2,
   output logic [NREQ-1:0]       res_val,
   input  logic [NREQ-1:0]       res_rdy,
   output logic [31:0]           res_data,
   output logic                  cal_val,
   input  logic                  cal_rdy,
   output logic [OPB_W-1:0]      cal_opb,
   output logic [31:0]           cal_opn1,
   output logic [31:0]           cal_opn2,
   input  logic                  cal_res_val,
   output logic                  cal_res_rdy,
   input  logic [31:0]           cal_res,
   output logic                  busy
);

   localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [GW-1:0]     gnt;
   logic [GW-1:0]     ptr;
   logic [GW-1:0]     win;
   logic [GW-1:0]     cand;
   logic              win_found;
   logic              accept;
   logic [OPB_W-1:0]  opb_r;
   logic [31:0]       opn1_r;
   logic [31:0]       opn2_r;
   logic [31:0]       res_r;

   logic [OPB_W-1:0]  opb_arr  [NREQ];
   logic [31:0]       opn1_arr [NREQ];
   logic [31:0]       opn2_arr [NREQ];

   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign opb_arr[i]  = req_opb[i*OPB_W +: OPB_W];
      assign opn1_arr[i] = req_opn1[i*32 +: 32];
      assign opn2_arr[i] = req_opn2[i*32 +: 32];
   end

   // Scan ptr+1, ptr+2, ... so the requester served last has the lowest priority.
   // NOTE: every variable written here gets a default first, so no latch can be inferred.
   always_comb begin : arbiter
      win       = '0;
      cand      = '0;
      win_found = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = GW'((int'(ptr) + k) % NREQ);
         if (!win_found && req_val[cand]) begin
            win       = cand;
            win_found = 1'b1;
         end
      end
   end

   // Held off during reset so no requester believes it was accepted by a resetting arbiter.
   assign accept = (state == IDLE) && win_found && !rst;

   always_comb begin : next_state
      state_nxt = state;
      case (state)
         IDLE:    if (accept)        state_nxt = ISSUE;
         ISSUE:   if (cal_rdy)       state_nxt = WAIT;
         WAIT:    if (cal_res_val)   state_nxt = RESP;
         RESP:    if (res_rdy[gnt])  state_nxt = IDLE;
         default:                    state_nxt = IDLE;
      endcase
   end

   // NOTE: state uses non-blocking assignments; data registers are reset too so that
   // cal_* and res_data read zero straight out of reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         ptr    <= GW'(NREQ - 1);
         gnt    <= '0;
         opb_r  <= '0;
         opn1_r <= '0;
         opn2_r <= '0;
         res_r  <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            gnt    <= win;
            opb_r  <= opb_arr[win];
            opn1_r <= opn1_arr[win];
            opn2_r <= opn2_arr[win];
         end
         if ((state == WAIT) && cal_res_val) begin
            res_r <= cal_res;
         end
         if ((state == RESP) && res_rdy[gnt]) begin
            ptr <= gnt;
         end
      end
   end

   assign req_rdy     = accept ? (NREQ'(1) << win) : '0;
   assign cal_val     = (state == ISSUE);
   assign cal_res_rdy = (state == WAIT);
   assign res_val     = (state == RESP) ? (NREQ'(1) << gnt) : '0;
   assign res_data    = res_r;
   assign cal_opb     = opb_r;
   assign cal_opn1    = opn1_r;
   assign cal_opn2    = opn2_r;
   assign busy        = (state != IDLE);

endmodule

// File: tb/tb_exu_cal_arb.sv
// Self-checking bench for exu_cal_arb: directed scenarios plus a randomized run against a
// transaction-level round-robin model. The bench plays the CAL as a biased adder.
module tb_exu_cal_arb;

   localparam int NREQ  = 2;
   localparam int OPB_W = 8;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic [NREQ-1:0]       req_val = '0;
   logic [NREQ-1:0]       req_rdy;
   logic [NREQ*OPB_W-1:0] req_opb = '0;
   logic [NREQ*32-1:0]    req_opn1 = '0;
   logic [NREQ*32-1:0]    req_opn2 = '0;
   logic [NREQ-1:0]       res_val;
   logic [NREQ-1:0]       res_rdy = '1;
   logic [31:0]           res_data;
   logic                  cal_val;
   logic                  cal_rdy = 1'b1;
   logic [OPB_W-1:0]      cal_opb;
   logic [31:0]           cal_opn1;
   logic [31:0]           cal_opn2;
   logic                  cal_res_val = 1'b1;
   logic                  cal_res_rdy;
   logic [31:0]           cal_res;
   logic                  busy;
   logic [31:0]           bias = '0;

   int tests = 0;
   int fails = 0;

   exu_cal_arb #(.NREQ(NREQ), .OPB_W(OPB_W)) dut (
      .clk(clk), .rst(rst),
      .req_val(req_val), .req_rdy(req_rdy), .req_opb(req_opb),
      .req_opn1(req_opn1), .req_opn2(req_opn2),
      .res_val(res_val), .res_rdy(res_rdy), .res_data(res_data),
      .cal_val(cal_val), .cal_rdy(cal_rdy), .cal_opb(cal_opb),
      .cal_opn1(cal_opn1), .cal_opn2(cal_opn2),
      .cal_res_val(cal_res_val), .cal_res_rdy(cal_res_rdy), .cal_res(cal_res),
      .busy(busy)
   );

   // CAL stand-in: a nonzero bias makes any stray capture visible in res_data.
   assign cal_res = cal_opn1 + cal_opn2 + bias;

   always #5 clk = ~clk;

   // Inputs change at the falling edge; outputs are sampled 1 time unit later.
   task automatic nxt();
      @(negedge clk);
   endtask

   task automatic set_op(input int i, input logic [OPB_W-1:0] opb,
                         input logic [31:0] a, input logic [31:0] b);
      req_opb[i*OPB_W +: OPB_W] = opb;
      req_opn1[i*32 +: 32]      = a;
      req_opn2[i*32 +: 32]      = b;
   endtask

   task automatic drain(input string name);
      bit done = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         nxt();
         req_val = '0; res_rdy = '1; cal_rdy = 1'b1; cal_res_val = 1'b1; bias = '0; rst = 1'b0;
         #1;
         if (!busy) done = 1'b1;
      end
      tests++;
      if (!done) begin
         fails++;
         $display("FAIL %s_drain_timeout busy=%b required=0", name, busy);
      end
   endtask

   task automatic apply_reset();
      nxt(); rst = 1'b1;
      nxt();
      nxt(); rst = 1'b0; req_val = '0;
   endtask

   task automatic test_reset();
      nxt(); rst = 1'b1; req_val = 2'b11;
      #1;
      tests++; if (req_rdy !== 2'b00) begin fails++; $display("FAIL reset_req_rdy got=%b exp=00", req_rdy); end
      tests++; if (res_val !== 2'b00) begin fails++; $display("FAIL reset_res_val got=%b exp=00", res_val); end
      tests++; if (cal_val !== 1'b0) begin fails++; $display("FAIL reset_cal_val got=%b exp=0", cal_val); end
      tests++; if (cal_res_rdy !== 1'b0) begin fails++; $display("FAIL reset_cal_res_rdy got=%b exp=0", cal_res_rdy); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
      tests++; if (res_data !== 32'd0) begin fails++; $display("FAIL reset_res_data got=%h exp=0", res_data); end
      tests++; if (cal_opb !== 8'd0) begin fails++; $display("FAIL reset_cal_opb got=%h exp=0", cal_opb); end
      tests++; if (cal_opn1 !== 32'd0) begin fails++; $display("FAIL reset_cal_opn1 got=%h exp=0", cal_opn1); end
      tests++; if (cal_opn2 !== 32'd0) begin fails++; $display("FAIL reset_cal_opn2 got=%h exp=0", cal_opn2); end
      nxt(); rst = 1'b0; req_val = '0;
   endtask

   task automatic test_single_op();
      nxt();
      req_val = 2'b01; set_op(0, 8'h11, 32'd5, 32'd7);
      cal_rdy = 1'b1; cal_res_val = 1'b1; res_rdy = 2'b11; bias = '0;
      #1;
      tests++; if (req_rdy !== 2'b01) begin fails++; $display("FAIL single_t0_req_rdy got=%b exp=01", req_rdy); end
      tests++; if (cal_val !== 1'b0) begin fails++; $display("FAIL single_t0_cal_val got=%b exp=0", cal_val); end
      nxt(); req_val = '0; #1;
      tests++; if (cal_val !== 1'b1) begin fails++; $display("FAIL single_t1_cal_val got=%b exp=1", cal_val); end
      tests++; if (cal_opn1 !== 32'd5 || cal_opn2 !== 32'd7 || cal_opb !== 8'h11) begin
         fails++; $display("FAIL single_t1_operands got=%h/%0d/%0d exp=11/5/7", cal_opb, cal_opn1, cal_opn2);
      end
      nxt(); #1;
      tests++; if (cal_res_rdy !== 1'b1 || cal_val !== 1'b0) begin
         fails++; $display("FAIL single_t2_wait cal_res_rdy=%b cal_val=%b exp=1/0", cal_res_rdy, cal_val);
      end
      nxt(); #1;
      tests++; if (res_val !== 2'b01) begin fails++; $display("FAIL single_t3_res_val got=%b exp=01", res_val); end
      tests++; if (res_data !== 32'd12) begin fails++; $display("FAIL single_t3_res_data got=%0d exp=12", res_data); end
      nxt(); #1;
      tests++; if (busy !== 1'b0 || res_val !== 2'b00) begin
         fails++; $display("FAIL single_t4_idle busy=%b res_val=%b exp=0/00", busy, res_val);
      end
   endtask

   task automatic test_round_robin();
      int grants = 0;
      apply_reset();
      for (int c = 0; c < 16; c++) begin
         nxt();
         req_val = 2'b11; set_op(0, 8'h01, $urandom, $urandom); set_op(1, 8'h02, $urandom, $urandom);
         cal_rdy = 1'b1; cal_res_val = 1'b1; res_rdy = 2'b11;
         #1;
         if (req_rdy !== 2'b00) begin
            tests++;
            if (req_rdy !== ((grants % 2 == 0) ? 2'b01 : 2'b10) || c != 4 * grants) begin
               fails++;
               $display("FAIL rr_grant got=%b at cycle %0d exp=%b at cycle %0d",
                        req_rdy, c, (grants % 2 == 0) ? 2'b01 : 2'b10, 4 * grants);
            end
            grants++;
         end
      end
      tests++; if (grants != 4) begin fails++; $display("FAIL rr_grant_count got=%0d exp=4", grants); end
      drain("rr");
   endtask

   task automatic test_cal_stall();
      logic [7:0]  e_opb = 8'($urandom);
      logic [31:0] e1 = $urandom;
      logic [31:0] e2 = $urandom;
      nxt();
      req_val = 2'b01; set_op(0, e_opb, e1, e2);
      cal_rdy = 1'b0; cal_res_val = 1'b0; res_rdy = 2'b11; bias = '0;
      #1;
      tests++; if (req_rdy !== 2'b01) begin fails++; $display("FAIL stall_accept got=%b exp=01", req_rdy); end
      for (int c = 0; c < 4; c++) begin
         nxt();
         req_val = '0; set_op(0, 8'($urandom), $urandom, $urandom);
         cal_rdy = (c == 3);
         #1;
         tests++; if (cal_val !== 1'b1 || cal_res_rdy !== 1'b0) begin
            fails++; $display("FAIL stall_issue_%0d cal_val=%b cal_res_rdy=%b exp=1/0", c, cal_val, cal_res_rdy);
         end
         tests++; if (cal_opb !== e_opb || cal_opn1 !== e1 || cal_opn2 !== e2) begin
            fails++; $display("FAIL stall_operands_%0d got=%h/%h/%h exp=%h/%h/%h",
                              c, cal_opb, cal_opn1, cal_opn2, e_opb, e1, e2);
         end
      end
      for (int c = 0; c < 6; c++) begin
         nxt();
         cal_rdy = 1'b0; cal_res_val = (c == 5); bias = (c == 5) ? 32'd0 : $urandom;
         #1;
         tests++; if (cal_res_rdy !== 1'b1 || cal_val !== 1'b0 || res_val !== 2'b00) begin
            fails++; $display("FAIL stall_wait_%0d cal_res_rdy=%b cal_val=%b res_val=%b exp=1/0/00",
                              c, cal_res_rdy, cal_val, res_val);
         end
      end
      nxt(); cal_res_val = 1'b0; #1;
      tests++; if (res_val !== 2'b01 || res_data !== e1 + e2) begin
         fails++; $display("FAIL stall_result res_val=%b res_data=%h exp=01/%h", res_val, res_data, e1 + e2);
      end
      drain("stall");
   endtask

   task automatic test_backpressure();
      nxt();
      req_val = 2'b01; set_op(0, 8'h05, 32'd100, 32'd1); set_op(1, 8'h06, 32'd2, 32'd3);
      res_rdy = 2'b00; cal_rdy = 1'b1; cal_res_val = 1'b1; bias = '0;
      #1;
      tests++; if (req_rdy !== 2'b01) begin fails++; $display("FAIL bp_accept got=%b exp=01", req_rdy); end
      nxt(); req_val = 2'b10; #1;
      nxt(); #1;
      for (int c = 0; c < 4; c++) begin
         nxt(); #1;
         tests++; if (res_val !== 2'b01 || req_rdy !== 2'b00) begin
            fails++; $display("FAIL bp_hold_%0d res_val=%b req_rdy=%b exp=01/00", c, res_val, req_rdy);
         end
      end
      nxt(); res_rdy = 2'b01; #1;
      tests++; if (res_val !== 2'b01 || res_data !== 32'd101) begin
         fails++; $display("FAIL bp_release res_val=%b res_data=%0d exp=01/101", res_val, res_data);
      end
      nxt(); #1;
      tests++; if (req_rdy !== 2'b10) begin fails++; $display("FAIL bp_next_grant got=%b exp=10", req_rdy); end
      drain("bp");
   endtask

   task automatic test_reset_mid_op();
      nxt();
      req_val = 2'b01; set_op(0, 8'h33, 32'd9, 32'd9);
      cal_rdy = 1'b1; cal_res_val = 1'b0; res_rdy = 2'b11; bias = '0;
      #1;
      nxt(); req_val = '0; #1;
      nxt(); #1;
      tests++; if (cal_res_rdy !== 1'b1) begin fails++; $display("FAIL rmid_in_wait got=%b exp=1", cal_res_rdy); end
      rst = 1'b1;
      nxt(); rst = 1'b0; cal_res_val = 1'b1; #1;
      tests++; if (busy !== 1'b0 || cal_val !== 1'b0 || cal_res_rdy !== 1'b0 || res_val !== 2'b00 || req_rdy !== 2'b00) begin
         fails++; $display("FAIL rmid_ctrl busy=%b cal_val=%b cal_res_rdy=%b res_val=%b req_rdy=%b exp=all 0",
                           busy, cal_val, cal_res_rdy, res_val, req_rdy);
      end
      tests++; if (res_data !== 32'd0 || cal_opn1 !== 32'd0 || cal_opb !== 8'd0) begin
         fails++; $display("FAIL rmid_data res_data=%h cal_opn1=%h cal_opb=%h exp=0", res_data, cal_opn1, cal_opb);
      end
      nxt(); #1;
      tests++; if (busy !== 1'b0 || res_val !== 2'b00 || res_data !== 32'd0) begin
         fails++; $display("FAIL rmid_late_res busy=%b res_val=%b res_data=%h exp=0/00/0", busy, res_val, res_data);
      end
      nxt(); req_val = 2'b11; #1;
      tests++; if (req_rdy !== 2'b01) begin fails++; $display("FAIL rmid_first_grant got=%b exp=01", req_rdy); end
      drain("rmid");
   endtask

   task automatic test_stray();
      logic [31:0] r0;
      nxt(); req_val = '0; cal_res_val = 1'b1; bias = 32'hDEAD_BEEF; res_rdy = 2'b11; #1;
      r0 = res_data;
      nxt(); #1;
      tests++; if (busy !== 1'b0 || res_data !== r0) begin
         fails++; $display("FAIL stray_idle busy=%b res_data=%h exp=0/%h", busy, res_data, r0);
      end
      nxt(); req_val = 2'b10; set_op(1, 8'h44, 32'd40, 32'd2); cal_rdy = 1'b0; #1;
      tests++; if (req_rdy !== 2'b10) begin fails++; $display("FAIL stray_accept got=%b exp=10", req_rdy); end
      nxt(); req_val = '0; #1;
      nxt(); cal_rdy = 1'b1; #1;
      tests++; if (cal_val !== 1'b1 || cal_res_rdy !== 1'b0) begin
         fails++; $display("FAIL stray_issue cal_val=%b cal_res_rdy=%b exp=1/0", cal_val, cal_res_rdy);
      end
      nxt(); cal_rdy = 1'b0; bias = '0; res_rdy = 2'b01; #1;
      nxt(); #1;
      tests++; if (res_val !== 2'b10 || res_data !== 32'd42) begin
         fails++; $display("FAIL stray_result res_val=%b res_data=%0d exp=10/42", res_val, res_data);
      end
      nxt(); #1;
      tests++; if (res_val !== 2'b10) begin fails++; $display("FAIL stray_other_rdy got=%b exp=10", res_val); end
      nxt(); res_rdy = 2'b10; #1;
      nxt(); #1;
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL stray_done busy=%b exp=0", busy); end
   endtask

   // Transaction-level model: pending requests per requester, one in-flight record.
   task automatic test_random();
      bit               pend [NREQ];
      logic [OPB_W-1:0] p_opb [NREQ];
      logic [31:0]      p_op1 [NREQ];
      logic [31:0]      p_op2 [NREQ];
      bit               t_act = 0, t_sent = 0, t_got = 0;
      int               t_idx = 0;
      logic [OPB_W-1:0] t_opb = '0;
      logic [31:0]      t_op1 = '0, t_op2 = '0, t_res = '0;
      int               last = NREQ - 1;
      int               sel;
      logic [NREQ-1:0]  e_rdy, e_res_val;
      bit               e_cal_val, e_cal_res_rdy;
      for (int i = 0; i < NREQ; i++) begin
         pend[i] = 0; p_opb[i] = '0; p_op1[i] = '0; p_op2[i] = '0;
      end
      apply_reset();
      for (int c = 0; c < 400; c++) begin
         nxt();
         for (int i = 0; i < NREQ; i++) begin
            if (pend[i] && $urandom_range(0, 15) == 0) pend[i] = 0;
            else if (!pend[i] && $urandom_range(0, 2) == 0) begin
               pend[i] = 1; p_opb[i] = 8'($urandom); p_op1[i] = $urandom; p_op2[i] = $urandom;
            end
            req_val[i] = pend[i];
            set_op(i, p_opb[i], p_op1[i], p_op2[i]);
         end
         cal_rdy = 1'($urandom_range(0, 1)); cal_res_val = 1'($urandom_range(0, 1));
         res_rdy = NREQ'($urandom); bias = $urandom;
         #1;
         sel = -1;
         if (!t_act) begin
            for (int k = 1; k <= NREQ; k++) begin
               if (sel < 0 && pend[(last + k) % NREQ]) sel = (last + k) % NREQ;
            end
         end
         e_rdy         = (sel >= 0) ? (NREQ'(1) << sel) : '0;
         e_cal_val     = t_act && !t_sent;
         e_cal_res_rdy = t_act && t_sent && !t_got;
         e_res_val     = (t_act && t_got) ? (NREQ'(1) << t_idx) : '0;
         tests++; if (req_rdy !== e_rdy) begin fails++; $display("FAIL rand_req_rdy c=%0d got=%b exp=%b", c, req_rdy, e_rdy); end
         tests++; if (cal_val !== e_cal_val) begin fails++; $display("FAIL rand_cal_val c=%0d got=%b exp=%b", c, cal_val, e_cal_val); end
         tests++; if (cal_res_rdy !== e_cal_res_rdy) begin fails++; $display("FAIL rand_cal_res_rdy c=%0d got=%b exp=%b", c, cal_res_rdy, e_cal_res_rdy); end
         tests++; if (res_val !== e_res_val) begin fails++; $display("FAIL rand_res_val c=%0d got=%b exp=%b", c, res_val, e_res_val); end
         tests++; if (busy !== t_act) begin fails++; $display("FAIL rand_busy c=%0d got=%b exp=%b", c, busy, t_act); end
         if (e_cal_val) begin
            tests++; if (cal_opb !== t_opb || cal_opn1 !== t_op1 || cal_opn2 !== t_op2) begin
               fails++; $display("FAIL rand_operands c=%0d got=%h/%h/%h exp=%h/%h/%h",
                                 c, cal_opb, cal_opn1, cal_opn2, t_opb, t_op1, t_op2);
            end
         end
         if (e_res_val != 0) begin
            tests++; if (res_data !== t_res) begin fails++; $display("FAIL rand_res_data c=%0d got=%h exp=%h", c, res_data, t_res); end
         end
         if (sel >= 0) begin
            t_act = 1; t_sent = 0; t_got = 0; t_idx = sel;
            t_opb = p_opb[sel]; t_op1 = p_op1[sel]; t_op2 = p_op2[sel];
            pend[sel] = 0;
         end else if (t_act && !t_sent) begin
            if (cal_rdy) t_sent = 1;
         end else if (t_act && !t_got) begin
            if (cal_res_val) begin t_got = 1; t_res = t_op1 + t_op2 + bias; end
         end else if (t_act) begin
            if (res_rdy[t_idx]) begin t_act = 0; last = t_idx; end
         end
      end
      drain("rand");
   endtask

   initial begin
      test_reset();
      test_single_op();
      test_round_robin();
      test_cal_stall();
      test_backpressure();
      test_reset_mid_op();
      test_stray();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
